// File: rtl/rchdc_feeder.sv
// rchdc_feeder: streams quantised features into the RCHDC core as level/position hypervectors
// and sequences its sample/set control. Define RCHDC_FEED_CNT_EN for the per-sample feature limit and sticky err.
module rchdc_feeder #(
  parameter int DIM      = 1024,
  parameter int FEAT_NUM = 617,
  parameter int FEAT_W   = 8,
  parameter int LVL_NUM  = 16,
  parameter int CLS_W    = 4,
  parameter int PRED_LAT = 2,
  parameter logic [DIM-1:0] POS_SEED = {{(DIM-1){1'b0}}, 1'b1},
  parameter logic [DIM-1:0] LVL_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_state,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [FEAT_W-1:0] s_feat,
  input  logic             s_last,
  input  logic [CLS_W-1:0] s_label,
  input  logic             s_set_last,
  output logic             state,
  output logic             smp_en,
  output logic             smp_clr,
  output logic             set_clr,
  output logic [DIM-1:0]   im_value,
  output logic [DIM-1:0]   im_pos,
  output logic [CLS_W-1:0] label,
  input  logic [CLS_W-1:0] predict,
  output logic             res_valid,
  output logic [CLS_W-1:0] res_class
`ifdef RCHDC_FEED_CNT_EN
  ,
  output logic             err
`endif
);

  localparam int LVL_W  = $clog2(LVL_NUM);
  localparam int SEG    = DIM / LVL_NUM;
  localparam int WAIT_W = $clog2(PRED_LAT + 2);

  if (LVL_NUM < 2 || (DIM % LVL_NUM) != 0 || FEAT_NUM < 1 || LVL_W > FEAT_W) begin : g_bad_cfg
    $error("rchdc_feeder: invalid parameter combination");
  end

  typedef enum logic [2:0] {IDLE, FEED, CLOSE, SETCLR, WAIT} fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic               accept;
  logic               first;
  logic               close_now;
  logic               set_last_q;
  logic               wait_done;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [FEAT_W-1:0]  q;
  logic [31:0]        shamt;
  logic [DIM-1:0]     lvl_mask;

  assign s_ready   = (fsm == IDLE) || (fsm == FEED);
  assign accept    = s_valid && s_ready;
  assign first     = (fsm == IDLE);
  assign wait_done = (wait_cnt == WAIT_W'(PRED_LAT));

  // Thermometer mask: level q flips the lowest q*SEG bits of the level seed.
  assign q        = s_feat >> (FEAT_W - LVL_W);
  assign shamt    = 32'(q) * 32'(SEG);
  assign lvl_mask = ~({DIM{1'b1}} << shamt);

`ifdef RCHDC_FEED_CNT_EN
  localparam int CNT_W = $clog2(FEAT_NUM + 1);

  logic [CNT_W-1:0] feat_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             force_last;

  assign cnt_inc    = first ? CNT_W'(1) : feat_cnt + CNT_W'(1);
  assign force_last = !s_last && (cnt_inc == CNT_W'(FEAT_NUM));
  assign close_now  = s_last || force_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      feat_cnt <= cnt_inc;
      if (force_last) err <= 1'b1;
    end
  end
`else
  assign close_now = s_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE, FEED: if (accept) fsm_nxt = close_now ? CLOSE : FEED;
      CLOSE: begin
        if (state)           fsm_nxt = WAIT;
        else if (set_last_q) fsm_nxt = SETCLR;
        else                 fsm_nxt = IDLE;
      end
      SETCLR:  fsm_nxt = IDLE;
      WAIT:    if (wait_done) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Every core-facing signal is a flop; strobes follow the FSM state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= 1'b0;
      label      <= '0;
      set_last_q <= 1'b0;
      smp_en     <= 1'b0;
      smp_clr    <= 1'b0;
      set_clr    <= 1'b0;
      im_value   <= LVL_SEED;
      im_pos     <= POS_SEED;
      wait_cnt   <= '0;
      res_valid  <= 1'b0;
      res_class  <= '0;
    end else begin
      smp_en    <= accept;
      smp_clr   <= (fsm == CLOSE);
      set_clr   <= (fsm == SETCLR);
      res_valid <= (fsm == WAIT) && wait_done;
      wait_cnt  <= (fsm == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (accept && first) begin
        state <= cfg_state;
        label <= s_label;
      end
      if (accept && close_now) set_last_q <= s_last && s_set_last;
      if (accept) begin
        im_value <= LVL_SEED ^ lvl_mask;
        im_pos   <= first ? POS_SEED : {im_pos[DIM-2:0], im_pos[DIM-1]};
      end
      if ((fsm == WAIT) && wait_done) res_class <= predict;
    end
  end

endmodule

// File: tb/tb_rchdc_feeder.sv
// tb_rchdc_feeder: table vectors, hand-written corner sequences and random samples checked
// against a transaction-level model of the feeder (also exercises RCHDC_FEED_CNT_EN when defined).
module tb_rchdc_feeder;

  localparam int DIM = 16, FEAT_NUM = 4, FEAT_W = 4, LVL_NUM = 4, CLS_W = 4, PRED_LAT = 2;
  localparam logic [15:0] POS_SEED = 16'h0001;
  localparam logic [15:0] LVL_SEED = 16'h0000;
`ifdef RCHDC_FEED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_state = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_set_last = 1'b0;
  logic [3:0]  s_feat = '0, s_label = '0, predict = '0;
  logic        s_ready, state, smp_en, smp_clr, set_clr, res_valid;
  logic [15:0] im_value, im_pos;
  logic [3:0]  label, res_class;
`ifdef RCHDC_FEED_CNT_EN
  logic        err;
`endif

  rchdc_feeder #(
    .DIM(DIM), .FEAT_NUM(FEAT_NUM), .FEAT_W(FEAT_W), .LVL_NUM(LVL_NUM), .CLS_W(CLS_W),
    .PRED_LAT(PRED_LAT), .POS_SEED(POS_SEED), .LVL_SEED(LVL_SEED)
  ) dut (
    .clk(clk), .rst(rst), .cfg_state(cfg_state), .s_valid(s_valid), .s_ready(s_ready),
    .s_feat(s_feat), .s_last(s_last), .s_label(s_label), .s_set_last(s_set_last),
    .state(state), .smp_en(smp_en), .smp_clr(smp_clr), .set_clr(set_clr),
    .im_value(im_value), .im_pos(im_pos), .label(label), .predict(predict),
    .res_valid(res_valid), .res_class(res_class)
`ifdef RCHDC_FEED_CNT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] val; logic [15:0] pos; logic st; logic [3:0] lab; } en_rec_t;
  typedef struct { int cyc; logic [3:0] cls; } res_rec_t;
  typedef struct { logic [3:0] feat; logic last; logic [15:0] exp_value; logic [15:0] exp_pos; } vec_t;

  en_rec_t  obs_en[$],  exp_en[$];
  int       obs_clr[$], exp_clr[$], obs_set[$], exp_set[$];
  res_rec_t obs_res[$], exp_res[$];

  int         tests = 0, fails = 0;
  int         ready_from = 0;
  bit         in_sample = 1'b0;
  int         idx = 0;
  logic       cur_mode = 1'b0;
  logic [3:0] cur_label = '0, last_cls = '0;
  bit         exp_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (smp_en)    obs_en.push_back('{cyc, im_value, im_pos, state, label});
      if (smp_clr)   obs_clr.push_back(cyc);
      if (set_clr)   obs_set.push_back(cyc);
      if (res_valid) obs_res.push_back('{cyc, res_class});
    end
  end

  function automatic logic [15:0] lvl_hv(logic [3:0] f);
    int q = int'(f) / ((1 << FEAT_W) / LVL_NUM);
    int n = q * (DIM / LVL_NUM);
    logic [15:0] m = '0;
    for (int b = 0; b < DIM; b++) m[b] = (b < n);
    return LVL_SEED ^ m;
  endfunction

  function automatic logic [15:0] pos_hv(int k);
    int r = k % DIM;
    if (r == 0) return POS_SEED;
    return (POS_SEED << r) | (POS_SEED >> (DIM - r));
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic go_idle(int n);
    s_valid = 1'b0; s_last = 1'b0; s_set_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one feature, waits for its handshake and records what the core must see.
  task automatic apply_stimulus(input logic cfg, input logic [3:0] feat, input logic last,
                                input logic [3:0] lab, input logic setl);
    int p, a;
    bit got, forced;
    cfg_state = cfg; s_feat = feat; s_last = last; s_label = lab; s_set_last = setl; s_valid = 1'b1;
    p = cyc; a = -1; got = 1'b0;
    if (!in_sample) begin
      cur_mode = cfg; cur_label = lab; idx = 0;
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (s_ready) begin a = cyc; got = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    check_output("accept_timeout", got, 1);
    if (!got) begin
      s_valid = 1'b0; in_sample = 1'b0;
      return;
    end
    check_output("accept_cycle", a, (p > ready_from) ? p : ready_from);
    exp_en.push_back('{a + 1, lvl_hv(feat), pos_hv(idx), cur_mode, cur_label});
    forced = CNT_EN && !last && (idx + 1 == FEAT_NUM);
    if (last || forced) begin
      exp_clr.push_back(a + 2);
      if (cur_mode) begin
        exp_res.push_back('{a + 3 + PRED_LAT, predict});
        last_cls = predict;
        ready_from = a + 3 + PRED_LAT;
      end else if (last && setl) begin
        exp_set.push_back(a + 3);
        ready_from = a + 3;
      end else begin
        ready_from = a + 2;
      end
      if (forced) exp_err = 1'b1;
      in_sample = 1'b0;
    end else begin
      idx++;
      ready_from = a + 1;
      in_sample = 1'b1;
    end
  endtask

  task automatic clear_queues();
    obs_en.delete(); exp_en.delete(); obs_clr.delete(); exp_clr.delete();
    obs_set.delete(); exp_set.delete(); obs_res.delete(); exp_res.delete();
  endtask

  task automatic flush_check(string tag);
    check_output({tag, "_en_count"}, obs_en.size(), exp_en.size());
    for (int i = 0; i < obs_en.size() && i < exp_en.size(); i++) begin
      check_output({tag, "_en_cycle"}, obs_en[i].cyc, exp_en[i].cyc);
      check_output({tag, "_im_value"}, obs_en[i].val, exp_en[i].val);
      check_output({tag, "_im_pos"},   obs_en[i].pos, exp_en[i].pos);
      check_output({tag, "_state"},    obs_en[i].st,  exp_en[i].st);
      check_output({tag, "_label"},    obs_en[i].lab, exp_en[i].lab);
    end
    check_output({tag, "_clr_count"}, obs_clr.size(), exp_clr.size());
    for (int i = 0; i < obs_clr.size() && i < exp_clr.size(); i++)
      check_output({tag, "_clr_cycle"}, obs_clr[i], exp_clr[i]);
    check_output({tag, "_set_count"}, obs_set.size(), exp_set.size());
    for (int i = 0; i < obs_set.size() && i < exp_set.size(); i++)
      check_output({tag, "_set_cycle"}, obs_set[i], exp_set[i]);
    check_output({tag, "_res_count"}, obs_res.size(), exp_res.size());
    for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
      check_output({tag, "_res_cycle"}, obs_res[i].cyc, exp_res[i].cyc);
      check_output({tag, "_res_class"}, obs_res[i].cls, exp_res[i].cls);
    end
    check_output({tag, "_res_hold"}, res_class, last_cls);
`ifdef RCHDC_FEED_CNT_EN
    check_output({tag, "_err"}, err, exp_err);
`endif
    clear_queues();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'h0, 1'b0, 16'h0000, 16'h0001};
    tbl[1] = '{4'h7, 1'b0, 16'h000F, 16'h0002};
    tbl[2] = '{4'hF, 1'b1, 16'h0FFF, 16'h0004};
    tbl[3] = '{4'h3, 1'b0, 16'h0000, 16'h0001};
    tbl[4] = '{4'h4, 1'b0, 16'h000F, 16'h0002};
    tbl[5] = '{4'h8, 1'b0, 16'h00FF, 16'h0004};
    tbl[6] = '{4'hC, 1'b1, 16'h0FFF, 16'h0008};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_state", state, 0);
    check_output("rst_smp_en", smp_en, 0);
    check_output("rst_smp_clr", smp_clr, 0);
    check_output("rst_set_clr", set_clr, 0);
    check_output("rst_im_value", im_value, LVL_SEED);
    check_output("rst_im_pos", im_pos, POS_SEED);
    check_output("rst_label", label, 0);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_res_class", res_class, 0);
    rst = 1'b0;
    ready_from = cyc;

    // Quantisation/position table: two TRAIN samples back to back.
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, tbl[i].feat, tbl[i].last, 4'h3, 1'b0);
    go_idle(PRED_LAT + 6);
    for (int i = 0; i < 7; i++) begin
      if (i < obs_en.size()) begin
        check_output("tbl_im_value", obs_en[i].val, tbl[i].exp_value);
        check_output("tbl_im_pos", obs_en[i].pos, tbl[i].exp_pos);
      end
    end
    flush_check("table");

    // TRAIN label 3, second sample closes the set; later labels and set_last on non-last ignored.
    apply_stimulus(1'b0, 4'h5, 1'b0, 4'h3, 1'b0);
    apply_stimulus(1'b0, 4'h9, 1'b1, 4'hC, 1'b0);
    apply_stimulus(1'b0, 4'hA, 1'b0, 4'h3, 1'b1);
    apply_stimulus(1'b0, 4'h2, 1'b1, 4'h6, 1'b1);
    s_valid = 1'b0;
    check_output("ready_close", s_ready, 0);
    @(posedge clk); #1;
    check_output("ready_setclr", s_ready, 0);
    @(posedge clk); #1;
    check_output("ready_after_set", s_ready, 1);
    go_idle(4);
    flush_check("setclr");

    // PREDICT with cfg_state toggled mid-sample.
    predict = 4'h5;
    apply_stimulus(1'b1, 4'h1, 1'b0, 4'h7, 1'b0);
    apply_stimulus(1'b0, 4'h6, 1'b0, 4'h2, 1'b0);
    apply_stimulus(1'b1, 4'hE, 1'b1, 4'h0, 1'b1);
    go_idle(PRED_LAT + 6);
    check_output("pred_state_latched", state, 1);
    flush_check("predict");
    predict = 4'hA;
    go_idle(3);
    check_output("pred_class_held", res_class, 4'h5);

    // Back-to-back TRAIN samples with s_valid held high.
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 4'(i * 3), (i == 2) || (i == 5), 4'h1, 1'b0);
    go_idle(PRED_LAT + 6);
    if (obs_en.size() >= 4) begin
      check_output("b2b_bubble", obs_en[3].cyc - obs_en[2].cyc, 2);
      check_output("b2b_pos_restart", obs_en[3].pos, 16'h0001);
    end else begin
      check_output("b2b_count", obs_en.size(), 6);
    end
    flush_check("b2b");

    // Reset in the middle of a PREDICT sample.
    apply_stimulus(1'b1, 4'h3, 1'b0, 4'h9, 1'b0);
    apply_stimulus(1'b1, 4'hB, 1'b0, 4'h9, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("midrst_smp_en", smp_en, 0);
    check_output("midrst_im_pos", im_pos, POS_SEED);
    check_output("midrst_im_value", im_value, LVL_SEED);
    check_output("midrst_state", state, 0);
    check_output("midrst_label", label, 0);
    clear_queues();
    in_sample = 1'b0; last_cls = '0; exp_err = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ready_from = cyc;
    go_idle(PRED_LAT + 6);
    check_output("midrst_no_clr", obs_clr.size(), 0);
    check_output("midrst_no_set", obs_set.size(), 0);
    check_output("midrst_no_res", obs_res.size(), 0);
    check_output("midrst_no_en", obs_en.size(), 0);
    clear_queues();

`ifdef RCHDC_FEED_CNT_EN
    // Feature limit: the FEAT_NUMth feature closes the sample and sets err.
    check_output("cnt_err_clear", err, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4'(i + 1), 1'b0, 4'h2, 1'b0);
    apply_stimulus(1'b0, 4'hF, 1'b1, 4'h2, 1'b0);
    go_idle(PRED_LAT + 6);
    flush_check("cnt");
    apply_stimulus(1'b0, 4'h4, 1'b1, 4'h1, 1'b0);
    go_idle(PRED_LAT + 6);
    flush_check("cnt_sticky");
`endif

    // Random samples: modes, labels, set_last, valid gaps and mid-sample cfg changes.
    for (int b = 0; b < 25; b++) begin
      int ns;
      predict = 4'($urandom);
      ns = $urandom_range(1, 3);
      for (int s = 0; s < ns; s++) begin
        int n;
        logic mode;
        logic [3:0] lab;
        n = $urandom_range(1, 6);
        mode = 1'($urandom);
        lab = 4'($urandom);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 3));
          apply_stimulus((i == 0) ? mode : 1'($urandom), 4'($urandom), (i == n - 1),
                         (i == 0) ? lab : 4'($urandom), 1'($urandom));
        end
      end
      go_idle(PRED_LAT + 6);
      flush_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rchdc_feeder.md
Name: rchdc_feeder

Overview:
- Host-side sequencer that drives the sample and set interface of the RCHDC classifier core and collects its prediction.
- Accepts a stream of quantised features over valid/ready and maps each one to a level hypervector (im_value) and a position hypervector (im_pos).
- Generates the smp_en / smp_clr / set_clr / label / state control timing that the core consumes, and returns the predicted class with a result-valid pulse.

Parameters:
- DIM, 1024: hypervector width; must equal the core's DIM.
- FEAT_NUM, 617: maximum features per sample.
- FEAT_W, 8: feature word width.
- LVL_NUM, 16: quantisation levels; power of 2, LVL_NUM <= 2^FEAT_W, DIM divisible by LVL_NUM.
- CLS_W, 4: class/label width; must equal the core's CLS_DW.
- PRED_LAT, 2: cycles from the smp_clr pulse until the core's predict output is valid.
- POS_SEED, DIM'h1: position hypervector for feature 0.
- LVL_SEED, DIM'h0: level hypervector for level 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_state  in  1  0=TRAIN, 1=PREDICT; sampled at the first feature of each sample
- s_valid  in  1  feature valid
- s_ready  out  1  feature ready
- s_feat  in  FEAT_W  feature value
- s_last  in  1  last feature of the sample
- s_label  in  CLS_W  sample label; sampled with the first feature
- s_set_last  in  1  TRAIN only: this sample closes the training set; sampled with s_last
- state  out  1  latched cfg_state, to core
- smp_en  out  1  accumulate strobe, to core
- smp_clr  out  1  sample close, to core
- set_clr  out  1  set close / AM write, to core
- im_value  out  DIM  level hypervector, to core
- im_pos  out  DIM  position hypervector, to core
- label  out  CLS_W  latched label, to core
- predict  in  CLS_W  prediction from core
- res_valid  out  1  one-cycle pulse when res_class is updated
- res_class  out  CLS_W  captured prediction, held until the next capture

Behaviour:
- Reset:
  - Async, active-high; releases the FSM to IDLE.
  - All outputs 0, except im_pos=POS_SEED and im_value=LVL_SEED.
  - Feature counter 0. Reset mid-sample discards the sample; no smp_clr or set_clr is issued.
- All outputs to the core are registered.
- s_ready=1 in IDLE and FEED only. A feature is accepted on a clock edge where s_valid & s_ready.
- For each accepted feature, in the next cycle:
  - smp_en=1 for exactly one cycle.
  - q = s_feat >> (FEAT_W - log2(LVL_NUM)).
  - im_value = LVL_SEED ^ mask, where mask has the low q*(DIM/LVL_NUM) bits set.
  - im_pos = POS_SEED rotated left by the feature index (0 for the first feature of the sample). Implemented as a rotate-by-1 register that reloads POS_SEED at the start of each sample.
- im_value and im_pos hold their value when smp_en=0.
- FSM:
  - IDLE: first accept latches state<=cfg_state and label<=s_label, then goes to FEED. If that feature also has s_last, go to CLOSE.
  - FEED: accepts features; an accept with s_last goes to CLOSE.
  - CLOSE: smp_clr=1 for one cycle, in the cycle immediately after the last smp_en; s_ready=0.
    - TRAIN with latched s_set_last=1: go to SETCLR.
    - TRAIN otherwise: go to IDLE.
    - PREDICT: go to WAIT.
  - SETCLR: set_clr=1 for one cycle, the cycle after smp_clr; then IDLE.
  - WAIT: count PRED_LAT cycles starting at the smp_clr cycle. On the final count, res_class<=predict and res_valid=1 the next cycle; then IDLE.
- state and label are stable from the first smp_en through the smp_clr or set_clr cycle. A cfg_state change mid-sample is ignored until the next sample.
- s_set_last is ignored in PREDICT. smp_clr and set_clr are never asserted in the same cycle as smp_en.
- Back-to-back samples: the earliest next accept is in the cycle after CLOSE (or SETCLR, or the res_valid cycle).
- Without the optional feature, features beyond FEAT_NUM are still accepted; the rotate counter wraps modulo DIM.

Optional Feature:
- Macro RCHDC_FEED_CNT_EN.
- Defined:
  - Adds output err (1 bit, sticky, cleared only by rst).
  - Adds a feature counter (width clog2(FEAT_NUM+1)).
  - When the FEAT_NUMth feature is accepted without s_last, it is treated as last (go to CLOSE) and err<=1.
  - An s_last on an empty sample is impossible by construction; the counter resets each sample.
- Undefined: no err port and no counter; only s_last closes a sample.

Test Plan:
- Reset values: DIM=16, LVL_NUM=4, FEAT_W=4, POS_SEED=16'h0001, LVL_SEED=16'h0000; assert rst mid-FEED -> all strobes 0 immediately, im_pos=16'h0001, no smp_clr follows.
- TRAIN, 3 features 4'h0, 4'h7, 4'hF (last on the third), no set_last:
  - smp_en on 3 consecutive cycles.
  - im_value = 16'h0000, 16'h000F, 16'h0FFF.
  - im_pos = 16'h0001, 16'h0002, 16'h0004.
  - smp_clr 1 cycle after the last smp_en; set_clr never asserted.
- TRAIN, label=3, 2 samples, second with set_last -> label=3 throughout; set_clr exactly 1 cycle after the second smp_clr; s_ready low during CLOSE and SETCLR.
- PREDICT, PRED_LAT=2, core predict tied to 4'h5 -> res_valid pulses 3 cycles after smp_clr, res_class=4'h5 held; cfg_state toggled mid-sample leaves state=1.
- Back-to-back: s_valid held high across 2 samples -> exactly one s_ready-low bubble between samples; im_pos restarts at 16'h0001.
- RCHDC_FEED_CNT_EN, FEAT_NUM=4, 5 features without s_last -> smp_clr after the 4th feature, err=1 and sticky, 5th feature starts a new sample.
